arb_req_agent: RTL

//  Requester-side agent for the NUM_REQ-wide req/gnt arbitration interface.
//  Per channel: counts pending jobs from upstream push pulses, raises req, waits for gnt,

---
 rtl/arb_req_pkg.sv | 40 ++++
 rtl/arb_req_if.sv | 35 +++
 rtl/arb_req_chan.sv | 180 ++++++++++++++++++
 rtl/arb_req_agent.sv | 63 ++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// -----------------------------------------------------------------------------
// arb_req_pkg
// Shared types, default parameter values and width helpers for the
// requester-side arbitration agent (arb_req_agent, arb_req_chan, arb_req_if).
// Optional feature macro used elsewhere in this slice: STARVE_MON_EN.
// -----------------------------------------------------------------------------
package arb_req_pkg;

  // Per-channel FSM state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  // Default configuration of the agent.
  localparam int NUM_REQ_DEF    = 32'sd4;
  localparam int BURST_LEN_DEF  = 32'sd4;
  localparam int PEND_W_DEF     = 32'sd3;
  localparam int STARVE_LIM_DEF = 32'sd16;

  // Beat-counter width: $clog2(BURST_LEN), never below 1 bit.
  function automatic int beat_w(input int burst_len);
    if (burst_len > 32'sd1) begin
      return $clog2(burst_len);
    end else begin
      return 32'sd1;
    end
  endfunction

  // Wait-counter width: enough bits to hold the value STARVE_LIM itself.
  function automatic int wait_w(input int starve_lim);
    if (starve_lim > 32'sd0) begin
      return $clog2(starve_lim + 32'sd1);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/arb_req_if.sv
// -----------------------------------------------------------------------------
// arb_req_if
// Bundle of the agent's job/arbitration signals.
//   push, gnt, clr_ovf : into the agent (job sources / arbiter / control)
//   req                : agent -> arbiter request
//   xfer_vld/xfer_last : transfer beat strobes per channel
//   pend_full, ovf     : pending-counter status
//   starve             : wait-limit flag (only active with STARVE_MON_EN)
// Modports: master = the agent, slave = its environment (sources + arbiter).
// -----------------------------------------------------------------------------
interface arb_req_if
  import arb_req_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] gnt;
  logic               clr_ovf;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] xfer_vld;
  logic [NUM_REQ-1:0] xfer_last;
  logic [NUM_REQ-1:0] pend_full;
  logic [NUM_REQ-1:0] ovf;
  logic [NUM_REQ-1:0] starve;

  modport master (
    input  push, gnt, clr_ovf,
    output req, xfer_vld, xfer_last, pend_full, ovf, starve
  );

  modport slave (
    output push, gnt, clr_ovf,
    input  req, xfer_vld, xfer_last, pend_full, ovf, starve
  );
endinterface

// File: rtl/arb_req_chan.sv
// -----------------------------------------------------------------------------
// arb_req_chan
// One requester channel: IDLE/REQ/XFER FSM, saturating pending-job counter,
// sticky overflow flag and (with STARVE_MON_EN) a saturating wait counter.
// Every output comes straight from a flop that is loaded with the decode of
// the next state, so outputs change only on clk edges or on reset.
// Ports:
//   clk, rst (async, active-high)
//   push     in  enqueue one job (1-cycle pulse)
//   gnt      in  grant from the arbiter, honoured only in REQ
//   clr_ovf  in  clear the sticky ovf flag (a same-cycle set wins)
//   req, xfer_vld, xfer_last, pend_full, ovf, starve  out (registered)
// Macro: STARVE_MON_EN builds the starvation monitor; otherwise starve = 0.
// -----------------------------------------------------------------------------
module arb_req_chan
  import arb_req_pkg::*;
#(
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int PEND_W     = PEND_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic gnt,
  input  logic clr_ovf,
  output logic req,
  output logic xfer_vld,
  output logic xfer_last,
  output logic pend_full,
  output logic ovf,
  output logic starve
);

  localparam int BW = beat_w(BURST_LEN);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 32'sd1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  // Reject configurations the counters cannot represent.
  if (BURST_LEN < 32'sd1 || PEND_W < 32'sd1 || STARVE_LIM < 32'sd1) begin : g_param_chk
    $error("arb_req_chan: BURST_LEN, PEND_W and STARVE_LIM must all be >= 1");
  end

  state_t            state_r, state_s;
  logic [BW-1:0]     beat_r, beat_s;
  logic [PEND_W-1:0] pend_r, pend_s;
  logic              take_s;
  logic              ovf_set_s;
  logic              ovf_s;
  logic              req_r, vld_r, last_r, full_r, ovf_r;

  // Next-state and beat-counter decode.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    take_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if ((pend_r != '0) || push) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (gnt) begin
          state_s = XFER;
          beat_s  = '0;
          take_s  = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      XFER: begin
        // The burst always runs to completion; gnt is not looked at here.
        if (beat_r == LAST_BEAT) begin
          state_s = IDLE;
          beat_s  = '0;
        end else begin
          beat_s  = beat_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        beat_s  = '0;
      end
    endcase
  end

  // Pending counter: a push and a grant in the same cycle cancel out; a push
  // into a full counter with no grant is dropped and flagged.
  always_comb begin
    pend_s    = pend_r;
    ovf_set_s = 1'b0;
    if (push && !take_s) begin
      if (pend_r == PEND_MAX) begin
        pend_s    = pend_r;
        ovf_set_s = 1'b1;
      end else begin
        pend_s    = pend_r + 1'b1;
      end
    end else if (take_s && !push) begin
      pend_s = pend_r - 1'b1;
    end else begin
      pend_s = pend_r;
    end
    if (ovf_set_s) begin
      ovf_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      beat_r  <= '0;
      pend_r  <= '0;
      ovf_r   <= 1'b0;
      req_r   <= 1'b0;
      vld_r   <= 1'b0;
      last_r  <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      req_r   <= (state_s != IDLE);
      vld_r   <= (state_s == XFER);
      last_r  <= (state_s == XFER) && (beat_s == LAST_BEAT);
      full_r  <= (pend_s == PEND_MAX);
    end
  end

  assign req       = req_r;
  assign xfer_vld  = vld_r;
  assign xfer_last = last_r;
  assign pend_full = full_r;
  assign ovf       = ovf_r;

`ifdef STARVE_MON_EN
  localparam int WW = wait_w(STARVE_LIM);
  localparam logic [WW-1:0] WAIT_LIM = WW'(STARVE_LIM);

  logic [WW-1:0] wait_r, wait_s;
  logic          starve_r;

  // Wait counter: counts REQ cycles, saturates at the limit, clears on grant.
  always_comb begin
    wait_s = wait_r;
    if (state_s == XFER) begin
      wait_s = '0;
    end else if ((state_r == REQ) && (wait_r != WAIT_LIM)) begin
      wait_s = wait_r + 1'b1;
    end else begin
      wait_s = wait_r;
    end
  end

  // Wait counter and starve flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_r   <= '0;
      starve_r <= 1'b0;
    end else begin
      wait_r   <= wait_s;
      starve_r <= (wait_s >= WAIT_LIM);
    end
  end

  assign starve = starve_r;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/arb_req_agent.sv
// -----------------------------------------------------------------------------
// arb_req_agent
// Requester-side agent for a NUM_REQ-wide req/gnt arbiter. Each channel counts
// pending jobs, requests, waits for its grant and then runs a BURST_LEN-beat
// transfer while holding req, dropping req for one cycle between bursts.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   bus (master)  arb_req_if: push/gnt/clr_ovf in; req, xfer_vld, xfer_last,
//                 pend_full, ovf, starve out (all registered)
// Macro: STARVE_MON_EN enables the per-channel starvation monitor.
// -----------------------------------------------------------------------------
module arb_req_agent
  import arb_req_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int PEND_W     = PEND_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic     clk,
  input  logic     rst,
  arb_req_if.master bus
);

  logic [NUM_REQ-1:0] req_s;
  logic [NUM_REQ-1:0] vld_s;
  logic [NUM_REQ-1:0] last_s;
  logic [NUM_REQ-1:0] full_s;
  logic [NUM_REQ-1:0] ovf_s;
  logic [NUM_REQ-1:0] starve_s;
  logic               clr_ovf_s;

  // One clear strobe fans out to every channel.
  assign clr_ovf_s = bus.clr_ovf;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    arb_req_chan #(
      .BURST_LEN  (BURST_LEN),
      .PEND_W     (PEND_W),
      .STARVE_LIM (STARVE_LIM)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.push[i]),
      .gnt       (bus.gnt[i]),
      .clr_ovf   (clr_ovf_s),
      .req       (req_s[i]),
      .xfer_vld  (vld_s[i]),
      .xfer_last (last_s[i]),
      .pend_full (full_s[i]),
      .ovf       (ovf_s[i]),
      .starve    (starve_s[i])
    );
  end

  assign bus.req       = req_s;
  assign bus.xfer_vld  = vld_s;
  assign bus.xfer_last = last_s;
  assign bus.pend_full = full_s;
  assign bus.ovf       = ovf_s;
  assign bus.starve    = starve_s;

endmodule
